// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired Mini-SRC control unit stepping fetch (T0-T2) and execute (T3-T6).
// Optional macro CTRL_STEP_EN adds a Step input and a PAUSE state after each instruction.
module ctrl_sequencer #(
  parameter int OPW        = 5,
  parameter int T1_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        Start,
  input  logic [31:0] IR_Data,
  input  logic        Mem_ready,
`ifdef CTRL_STEP_EN
  input  logic        Step,
`endif
  output logic        PC_out,
  output logic        MAR_in,
  output logic        IncPC,
  output logic        Z_in,
  output logic        Zlow_out,
  output logic        Zhigh_out,
  output logic        PC_in,
  output logic        Read,
  output logic        MDR_in,
  output logic        MDR_out,
  output logic        IR_in,
  output logic        Y_in,
  output logic        HI_in,
  output logic        LO_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        R_in,
  output logic        R_out,
  output logic [4:0]  alu_instruction,
  output logic        Running,
  output logic        Halted,
  output logic        Err
);

  localparam int CW = (T1_TIMEOUT < 2) ? 1 : $clog2(T1_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6,
`ifdef CTRL_STEP_EN
    S_PAUSE,
`endif
    S_HALTED
  } state_t;

  typedef enum logic [2:0] {C_3OP, C_2OP, C_MULDIV, C_NOP, C_HALT, C_ILL} cls_t;

  typedef struct packed {
    logic       pc_out;
    logic       mar_in;
    logic       inc_pc;
    logic       z_in;
    logic       zlow_out;
    logic       zhigh_out;
    logic       read;
    logic       mdr_in;
    logic       mdr_out;
    logic       ir_in;
    logic       y_in;
    logic       hi_in;
    logic       lo_in;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       r_in;
    logic       r_out;
    logic [4:0] alu;
    logic       running;
  } ctl_t;

`ifdef CTRL_STEP_EN
  localparam state_t S_DONE = S_PAUSE;
`else
  localparam state_t S_DONE = S_T0;
`endif

  function automatic cls_t classify(input logic [OPW-1:0] op);
    cls_t k;
    case (5'(op))
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: k = C_3OP;
      5'b10001, 5'b10010:                     k = C_2OP;
      5'b10000, 5'b01111:                     k = C_MULDIV;
      5'b11010:                               k = C_NOP;
      5'b11011:                               k = C_HALT;
      default:                                k = C_ILL;
    endcase
    return k;
  endfunction

  // Strobe pattern for a given state; at most one bus driver is ever set.
  function automatic ctl_t decode(input state_t s, input logic [OPW-1:0] op);
    ctl_t c;
    cls_t k;
    c = '0;
    k = classify(op);
    case (s)
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1; c.z_in = 1'b1;
      end
      S_T1: begin
        c.zlow_out = 1'b1; c.read = 1'b1; c.mdr_in = 1'b1;
      end
      S_T2: begin
        c.mdr_out = 1'b1; c.ir_in = 1'b1;
      end
      S_T3: begin
        case (k)
          C_3OP:    begin c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          C_2OP:    begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu = 5'(op); end
          C_MULDIV: begin c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1; end
          default:  ;
        endcase
      end
      S_T4: begin
        case (k)
          C_3OP:    begin c.grc = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu = 5'(op); end
          C_2OP:    begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_MULDIV: begin c.grb = 1'b1; c.r_out = 1'b1; c.z_in = 1'b1; c.alu = 5'(op); end
          default:  ;
        endcase
      end
      S_T5: begin
        case (k)
          C_3OP:    begin c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1; end
          C_MULDIV: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          default:  ;
        endcase
      end
      S_T6: begin
        c.zhigh_out = 1'b1; c.hi_in = 1'b1;
      end
      default: ;
    endcase
    c.running = (s == S_T0) || (s == S_T1) || (s == S_T2) || (s == S_T3) ||
                (s == S_T4) || (s == S_T5) || (s == S_T6);
    return c;
  endfunction

  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic           err_set;
  ctl_t           ctl_q;
  cls_t           cls_q;
  logic           unused_ir;

  assign unused_ir = ^IR_Data[31-OPW:0];
  assign cls_q     = classify(op_q);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = '0;
    err_set = 1'b0;
    case (state_q)
      S_IDLE: if (Start) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1: begin
        if (Mem_ready) begin
          state_d = S_T2;
        end else if (wait_q == CW'(T1_TIMEOUT - 1)) begin
          state_d = S_HALTED;
          err_set = 1'b1;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_T2: begin
        state_d = S_T3;
        op_d    = IR_Data[31 -: OPW];
      end
      S_T3: begin
        case (cls_q)
          C_3OP, C_2OP, C_MULDIV: state_d = S_T4;
          C_NOP:                  state_d = S_DONE;
          C_HALT:                 state_d = S_HALTED;
          default: begin
            state_d = S_HALTED;
            err_set = 1'b1;
          end
        endcase
      end
      S_T4:     state_d = (cls_q == C_2OP) ? S_DONE : S_T5;
      S_T5:     state_d = (cls_q == C_3OP) ? S_DONE : S_T6;
      S_T6:     state_d = S_DONE;
`ifdef CTRL_STEP_EN
      S_PAUSE:  if (Step) state_d = S_T0;
`endif
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state_q.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      ctl_q   <= '0;
      Halted  <= 1'b0;
      Err     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      ctl_q   <= decode(state_d, op_d);
      Halted  <= (state_d == S_HALTED);
      Err     <= Err | err_set;
    end
  end

  // PC reload is the only strobe that follows Mem_ready within the same T1 cycle.
  assign PC_in = (state_q == S_T1) && Mem_ready;

  assign PC_out          = ctl_q.pc_out;
  assign MAR_in          = ctl_q.mar_in;
  assign IncPC           = ctl_q.inc_pc;
  assign Z_in            = ctl_q.z_in;
  assign Zlow_out        = ctl_q.zlow_out;
  assign Zhigh_out       = ctl_q.zhigh_out;
  assign Read            = ctl_q.read;
  assign MDR_in          = ctl_q.mdr_in;
  assign MDR_out         = ctl_q.mdr_out;
  assign IR_in           = ctl_q.ir_in;
  assign Y_in            = ctl_q.y_in;
  assign HI_in           = ctl_q.hi_in;
  assign LO_in           = ctl_q.lo_in;
  assign Gra             = ctl_q.gra;
  assign Grb             = ctl_q.grb;
  assign Grc             = ctl_q.grc;
  assign R_in            = ctl_q.r_in;
  assign R_out           = ctl_q.r_out;
  assign alu_instruction = ctl_q.alu;
  assign Running         = ctl_q.running;

endmodule
